// File: rtl/mcu_pkg.sv
// Shared MCU definitions: interrupt controller port IDs, state type and vector width.
package mcu_pkg;

    localparam logic [7:0] MASK_ID = 8'hE0;
    localparam logic [7:0] PEND_ID = 8'hE1;
    localparam logic [7:0] VEC_ID  = 8'hE2;

    localparam int VEC_W = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } int_st_t;

endpackage

// File: rtl/prio_enc.sv
// Lowest-index-wins priority encoder: bit 0 has the highest priority.
module prio_enc
    import mcu_pkg::*;
#(
    parameter int N_SRC = 8
) (
    input  logic [N_SRC-1:0] req,
    output logic             valid,
    output logic [VEC_W-1:0] idx
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        valid = |req;
        idx   = {VEC_W{1'b0}};
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = i[VEC_W-1:0];
            end else begin
                idx = idx;
            end
        end
    end

endmodule

// File: rtl/int_arbiter.sv
// Multi-source interrupt arbiter: edge-latched pending bits, software mask,
// fixed-priority winner and a REQ/SERVICE handshake with the control unit.
module int_arbiter
    import mcu_pkg::*;
#(
    parameter int         N_SRC   = 8,
    parameter logic [7:0] MASK_ID = mcu_pkg::MASK_ID,
    parameter logic [7:0] PEND_ID = mcu_pkg::PEND_ID,
    parameter logic [7:0] VEC_ID  = mcu_pkg::VEC_ID
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [N_SRC-1:0] IRQ,
    input  logic [7:0]       PORT_ID,
    input  logic [7:0]       OUT_PORT,
    input  logic             IO_STRB,
    output logic [7:0]       IN_DATA,
    input  logic             INT_ACK,
    input  logic             INT_DONE,
    output logic             INT_REQ,
    output logic             BUSY
);

    logic [N_SRC-1:0] irq_q_r;
    logic [N_SRC-1:0] mask_r;
    logic [N_SRC-1:0] pending_r;
    logic [VEC_W-1:0] vec_r;
    int_st_t          state_r;
    logic             int_req_r;
    logic             busy_r;

    logic [N_SRC-1:0] rise_s;
    logic [N_SRC-1:0] cand_s;
    logic [N_SRC-1:0] vec_onehot_s;
    logic [N_SRC-1:0] w1c_s;
    logic [N_SRC-1:0] ack_clr_s;
    logic [N_SRC-1:0] pending_nxt_s;
    logic [N_SRC-1:0] mask_nxt_s;
    logic             mask_wr_s;
    logic             pend_wr_s;
    logic             ack_fire_s;
    logic             vec_live_s;
    logic             win_valid_s;
    logic [VEC_W-1:0] win_idx_s;
    logic [7:0]       in_data_s;

    assign cand_s = pending_r & mask_r;

    prio_enc #(
        .N_SRC (N_SRC)
    ) u_prio_enc (
        .req   (cand_s),
        .valid (win_valid_s),
        .idx   (win_idx_s)
    );

    // Next-cycle pending/mask values; the REQ drop check looks at these so a
    // mask write or W1C withdraws the request on the very edge it lands.
    always_comb begin
        rise_s     = IRQ & ~irq_q_r;
        mask_wr_s  = IO_STRB && (PORT_ID == MASK_ID);
        pend_wr_s  = IO_STRB && (PORT_ID == PEND_ID);
        ack_fire_s = (state_r == REQ) && INT_ACK;
        for (int i = 0; i < N_SRC; i++) begin
            vec_onehot_s[i] = (vec_r == i[VEC_W-1:0]);
        end
        w1c_s         = pend_wr_s  ? OUT_PORT[N_SRC-1:0] : {N_SRC{1'b0}};
        ack_clr_s     = ack_fire_s ? vec_onehot_s        : {N_SRC{1'b0}};
        // New edges are OR-ed in after the clear so a same-cycle rise wins.
        pending_nxt_s = (pending_r & ~(w1c_s | ack_clr_s)) | rise_s;
        mask_nxt_s    = mask_wr_s  ? OUT_PORT[N_SRC-1:0] : mask_r;
        vec_live_s    = |(pending_nxt_s & mask_nxt_s & vec_onehot_s);
    end

    // Edge-detect history, mask register and pending register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            irq_q_r   <= {N_SRC{1'b0}};
            mask_r    <= {N_SRC{1'b0}};
            pending_r <= {N_SRC{1'b0}};
        end else begin
            irq_q_r   <= IRQ;
            mask_r    <= mask_nxt_s;
            pending_r <= pending_nxt_s;
        end
    end

    // Request/service handshake with registered INT_REQ and BUSY.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r   <= IDLE;
            vec_r     <= {VEC_W{1'b0}};
            int_req_r <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    busy_r <= 1'b0;
                    if (win_valid_s) begin
                        vec_r     <= win_idx_s;
                        state_r   <= REQ;
                        int_req_r <= 1'b1;
                    end else begin
                        int_req_r <= 1'b0;
                    end
                end
                REQ: begin
                    // vec_r stays frozen here: no preemption by later arrivals.
                    if (INT_ACK) begin
                        state_r   <= SERVICE;
                        int_req_r <= 1'b0;
                        busy_r    <= 1'b1;
                    end else if (!vec_live_s) begin
                        state_r   <= IDLE;
                        int_req_r <= 1'b0;
                        busy_r    <= 1'b0;
                    end else begin
                        int_req_r <= 1'b1;
                        busy_r    <= 1'b0;
                    end
                end
                SERVICE: begin
                    int_req_r <= 1'b0;
                    if (INT_DONE) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        busy_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    int_req_r <= 1'b0;
                    busy_r    <= 1'b0;
                end
            endcase
        end
    end

    // IN-port read mux, zero-extended; unmatched IDs read as zero.
    always_comb begin
        in_data_s = 8'h00;
        if (PORT_ID == MASK_ID) begin
            in_data_s[N_SRC-1:0] = mask_r;
        end else if (PORT_ID == PEND_ID) begin
            in_data_s[N_SRC-1:0] = pending_r;
        end else if (PORT_ID == VEC_ID) begin
            in_data_s[VEC_W-1:0] = vec_r;
        end else begin
            in_data_s = 8'h00;
        end
    end

    assign IN_DATA = in_data_s;
    assign INT_REQ = int_req_r;
    assign BUSY    = busy_r;

endmodule
